rotor_driver: RTL and testbench
===============================

// Module: rotor_driver
// PURPOSE
//  Initiator side of the rotor handshake: accepts ASCII letters from upstream, runs one rotor
//  transaction per letter (issue, step, wait for done, capture) and returns the substituted
//  letter downstream. Also forwards configuration to the rotor via a one-cycle set pulse.
//  Sits between the character front end and one rotor instance. Chains instantiate one per rotor.
// PARAMETERS
//  TIMEOUT    200  max WAIT cycles before r_done is declared lost (must be < 2**TW)
//  TW         8    width of the timeout counter
// PORTS
//  clk        in   1    clock
//  reset_n    in   1    asynchronous active-low reset
//  cfg_valid  in   1    config request. Sampled only in IDLE.
//  cfg_offset in   32   rotor step per en cycle
//  cfg_delay  in   32   rotor delay setting
//  cfg_idx    in   208  26x8 wiring table, 'A' entry in [207:200]
//  mode_dec   in   1    0 = encode, 1 = decode. Latched with each accepted letter.
//  in_valid   in   1    upstream letter valid
//  in_ready   out  1    upstream ready
//  in_char    in   8    upstream letter (ASCII)
//  out_valid  out  1    result valid
//  out_ready  in   1    downstream ready
//  out_char   out  8    result letter
//  err        out  1    one-cycle error pulse (bad letter or timeout)
//  r_set      out  1    to rotor: config load
//  r_offset   out  32   to rotor
//  r_delay    out  32   to rotor
//  r_idx      out  208  to rotor
//  r_valid    out  1    to rotor: letter load
//  r_din      out  8    to rotor
//  r_dec      out  1    to rotor: direction
//  r_en       out  1    to rotor: step enable
//  r_dout     in   8    from rotor
//  r_done     in   1    from rotor: result valid, one cycle
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except in_ready = 1 when cfg_valid = 0; registers cleared.
//  States: IDLE, CFG, ISSUE, WAIT, HOLD.
//  IDLE:
//   - in_ready = !cfg_valid. cfg_valid has priority over in_valid in the same cycle.
//   - cfg_valid: register cfg_*, go to CFG.
//   - in_valid & in_ready, in_char in 65..90: register char and mode_dec, go to ISSUE.
//   - in_valid & in_ready, in_char outside 65..90: the letter is consumed, err pulses next
//     cycle, no rotor transaction, stay in IDLE.
//  CFG: r_set = 1 for exactly 1 cycle; r_offset/r_delay/r_idx are driven from registers and
//   held at all times. Then go to IDLE.
//  ISSUE: r_valid = 1 and r_din/r_dec valid for exactly 1 cycle; clear timeout counter; go to WAIT.
//  WAIT:
//   - r_en = !r_done; the counter increments each cycle.
//   - r_done: capture r_dout into out_char, go to HOLD. r_en is low in this cycle, so no extra step.
//   - counter reaches TIMEOUT-1 without r_done: err pulse, go to IDLE, no output.
//  HOLD:
//   - out_valid = 1; out_char stable until out_ready.
//   - out_valid & out_ready: go to IDLE. The next letter can be accepted 1 cycle later.
//  r_done outside WAIT is ignored.
//  r_din/r_dec hold their last value outside ISSUE. r_valid, r_set and r_en are 0 outside their states.
//  Latency: letter accept -> out_valid = 2 + N cycles, where N = cycles from r_valid to r_done.
//  Reset mid-operation: immediate IDLE. Pending letter and output are dropped, no err pulse.
//  Arithmetic: the timeout counter is TW bits, saturates, and never wraps.
// TESTING
//  1. cfg_valid 1 cycle (offset=1, delay=3) -> r_set high exactly 1 cycle, then r_offset=1 and r_delay=3 are held.
//  2. in_char 'A', enc; model asserts r_done with r_dout='E' 3 cycles after r_valid -> r_valid 1 cycle,
//     r_en high 2 cycles, out_valid with out_char='E' 5 cycles after accept.
//  3. out_ready held 0 for 10 cycles in HOLD -> out_char stable and in_ready=0 throughout;
//     on release, in_ready=1 the next cycle.
//  4. in_char 0x5B ('[') -> err pulse 1 cycle, r_valid never asserted, in_ready stays 1.
//  5. Model never asserts r_done -> r_en high TIMEOUT cycles, err pulse, back to IDLE, out_valid stays 0.
//  6. cfg_valid and in_valid together -> CFG first, letter not accepted; reset_n low in WAIT ->
//     all outputs 0 the same cycle.

Source files
------------

// File: rtl/rotor_driver.sv
// Initiator side of the rotor handshake: one issue/step/wait/capture transaction per
// accepted letter, plus a one-cycle set pulse that forwards configuration to the rotor.
module rotor_driver #(
  parameter int TIMEOUT = 200,
  parameter int TW      = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cfg_valid,
  input  logic [31:0]  cfg_offset,
  input  logic [31:0]  cfg_delay,
  input  logic [207:0] cfg_idx,
  input  logic         mode_dec,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_char,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_char,
  output logic         err,
  output logic         r_set,
  output logic [31:0]  r_offset,
  output logic [31:0]  r_delay,
  output logic [207:0] r_idx,
  output logic         r_valid,
  output logic [7:0]   r_din,
  output logic         r_dec,
  output logic         r_en,
  input  logic [7:0]   r_dout,
  input  logic         r_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_t;

  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] WAIT_MAX  = '1;

  state_t        state;
  logic [TW-1:0] wait_cnt;
  logic [7:0]    char_q;
  logic          dec_q;
  logic          letter_ok;

  assign letter_ok = (in_char >= 8'd65) && (in_char <= 8'd90);

  // Config takes precedence, so the upstream is stalled in any cycle cfg_valid is up.
  assign in_ready = (state == S_IDLE) && !cfg_valid;

  // The step enable must drop in the very cycle r_done arrives, so it cannot be a flop.
  assign r_en = (state == S_WAIT) && !r_done;

  assign r_din = char_q;
  assign r_dec = dec_q;

  // NOTE: every register here uses <= so all of them update from the same pre-edge values;
  // a blocking = would let later statements see half-updated state and mis-simulate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the config registers are plain flops (not a memory array), so clearing them
      // on reset costs nothing and keeps r_offset/r_delay/r_idx at 0 until configured.
      state     <= S_IDLE;
      wait_cnt  <= '0;
      char_q    <= '0;
      dec_q     <= 1'b0;
      out_char  <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      r_set     <= 1'b0;
      r_valid   <= 1'b0;
      r_offset  <= '0;
      r_delay   <= '0;
      r_idx     <= '0;
    end else begin
      r_set   <= 1'b0;
      r_valid <= 1'b0;
      err     <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cfg_valid) begin
            r_offset <= cfg_offset;
            r_delay  <= cfg_delay;
            r_idx    <= cfg_idx;
            r_set    <= 1'b1;
            state    <= S_CFG;
          end else if (in_valid) begin
            if (letter_ok) begin
              char_q  <= in_char;
              dec_q   <= mode_dec;
              r_valid <= 1'b1;
              state   <= S_ISSUE;
            end else begin
              // Non-letters are swallowed and flagged without touching the rotor.
              err <= 1'b1;
            end
          end
        end

        S_CFG: state <= S_IDLE;

        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          if (r_done) begin
            out_char  <= r_dout;
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end else if (wait_cnt == WAIT_LAST) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rotor_driver.sv
// Directed bench for rotor_driver: config pulse, normal transaction, backpressure, bad
// letter, timeout, config/letter collision, reset in WAIT and a fastest-possible rotor.
module tb_rotor_driver;

  localparam int TIMEOUT = 200;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cfg_valid;
  logic [31:0]  cfg_offset;
  logic [31:0]  cfg_delay;
  logic [207:0] cfg_idx;
  logic         mode_dec;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_char;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_char;
  logic         err;
  logic         r_set;
  logic [31:0]  r_offset;
  logic [31:0]  r_delay;
  logic [207:0] r_idx;
  logic         r_valid;
  logic [7:0]   r_din;
  logic         r_dec;
  logic         r_en;
  logic [7:0]   r_dout;
  logic         r_done;

  int n_chk  = 0;
  int n_fail = 0;

  rotor_driver #(.TIMEOUT(TIMEOUT), .TW(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_valid  (cfg_valid),
    .cfg_offset (cfg_offset),
    .cfg_delay  (cfg_delay),
    .cfg_idx    (cfg_idx),
    .mode_dec   (mode_dec),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_char    (in_char),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_char   (out_char),
    .err        (err),
    .r_set      (r_set),
    .r_offset   (r_offset),
    .r_delay    (r_delay),
    .r_idx      (r_idx),
    .r_valid    (r_valid),
    .r_din      (r_din),
    .r_dec      (r_dec),
    .r_en       (r_en),
    .r_dout     (r_dout),
    .r_done     (r_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [207:0] idx_pat;
    int           en_cnt;
    bit           saw_ov;
    bit           saw_err;

    idx_pat    = {8'h42, {25{8'h43}}};
    reset_n    = 1'b0;
    cfg_valid  = 1'b0;
    cfg_offset = '0;
    cfg_delay  = '0;
    cfg_idx    = '0;
    mode_dec   = 1'b0;
    in_valid   = 1'b0;
    in_char    = '0;
    out_ready  = 1'b0;
    r_dout     = '0;
    r_done     = 1'b0;

    // Reset state
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_r_set", r_set, 1'b0);
    chk("rst_r_valid", r_valid, 1'b0);
    chk("rst_r_en", r_en, 1'b0);
    chk("rst_r_offset", r_offset, 32'd0);
    reset_n = 1'b1;
    tick();

    // Config and letter together: config wins, letter is not taken
    cfg_valid  = 1'b1;
    cfg_offset = 32'd1;
    cfg_delay  = 32'd3;
    cfg_idx    = idx_pat;
    in_valid   = 1'b1;
    in_char    = 8'h42;
    #1;
    chk("collide_in_ready", in_ready, 1'b0);
    tick();
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    #1;
    chk("cfg_r_set_hi", r_set, 1'b1);
    chk("cfg_r_offset", r_offset, 32'd1);
    chk("cfg_r_delay", r_delay, 32'd3);
    chk("cfg_r_idx", r_idx, idx_pat);
    chk("cfg_in_ready_low", in_ready, 1'b0);
    tick();
    chk("cfg_r_set_lo", r_set, 1'b0);
    chk("cfg_offset_held", r_offset, 32'd1);
    chk("cfg_delay_held", r_delay, 32'd3);
    chk("collide_no_r_valid", r_valid, 1'b0);
    tick();
    chk("collide_no_r_valid2", r_valid, 1'b0);
    chk("idle_in_ready", in_ready, 1'b1);

    // 'A' encode; rotor answers 'E' three cycles after r_valid
    in_valid = 1'b1;
    in_char  = 8'h41;
    mode_dec = 1'b0;
    #1;
    chk("a_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("a_r_valid", r_valid, 1'b1);
    chk("a_r_din", r_din, 8'h41);
    chk("a_r_dec", r_dec, 1'b0);
    chk("a_r_en_issue", r_en, 1'b0);
    tick();
    chk("a_r_valid_drop", r_valid, 1'b0);
    chk("a_r_en_1", r_en, 1'b1);
    tick();
    chk("a_r_en_2", r_en, 1'b1);
    tick();
    r_done = 1'b1;
    r_dout = 8'h45;
    #1;
    chk("a_r_en_done", r_en, 1'b0);
    chk("a_no_out_yet", out_valid, 1'b0);
    tick();
    r_done = 1'b0;
    r_dout = 8'h00;
    #1;
    chk("a_out_valid", out_valid, 1'b1);
    chk("a_out_char", out_char, 8'h45);
    chk("a_r_en_hold", r_en, 1'b0);

    // Backpressure for 10 cycles; a stray r_done in HOLD must be ignored
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        r_done = 1'b1;
        r_dout = 8'h5A;
      end else begin
        r_done = 1'b0;
        r_dout = 8'h00;
      end
      tick();
      chk("hold_out_char", out_char, 8'h45);
      chk("hold_in_ready", in_ready, 1'b0);
      chk("hold_out_valid", out_valid, 1'b1);
    end
    r_done    = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    chk("release_out_valid", out_valid, 1'b0);
    chk("release_in_ready", in_ready, 1'b1);

    // '[' just above 'Z' and '@' just below 'A' are both rejected
    in_valid = 1'b1;
    in_char  = 8'h5B;
    tick();
    in_valid = 1'b0;
    #1;
    chk("bad5b_err", err, 1'b1);
    chk("bad5b_r_valid", r_valid, 1'b0);
    chk("bad5b_in_ready", in_ready, 1'b1);
    tick();
    chk("bad5b_err_drop", err, 1'b0);
    chk("bad5b_r_valid2", r_valid, 1'b0);
    in_valid = 1'b1;
    in_char  = 8'h40;
    tick();
    in_valid = 1'b0;
    #1;
    chk("bad40_err", err, 1'b1);
    chk("bad40_r_valid", r_valid, 1'b0);
    tick();

    // 'Z' decode with a rotor that never answers: timeout
    in_valid = 1'b1;
    in_char  = 8'h5A;
    mode_dec = 1'b1;
    tick();
    in_valid = 1'b0;
    mode_dec = 1'b0;
    #1;
    chk("z_r_valid", r_valid, 1'b1);
    chk("z_r_din", r_din, 8'h5A);
    chk("z_r_dec", r_dec, 1'b1);
    en_cnt  = 0;
    saw_ov  = 1'b0;
    saw_err = 1'b0;
    for (int i = 0; i < TIMEOUT + 50; i++) begin
      tick();
      if (r_en) en_cnt++;
      if (out_valid) saw_ov = 1'b1;
      if (err) begin
        saw_err = 1'b1;
        break;
      end
    end
    chk("to_err_seen", saw_err, 1'b1);
    chk("to_r_en_cycles", en_cnt, TIMEOUT);
    chk("to_no_out_valid", saw_ov, 1'b0);
    chk("to_in_ready", in_ready, 1'b1);
    chk("to_r_din_held", r_din, 8'h5A);
    tick();
    chk("to_err_drop", err, 1'b0);

    // Reset while in WAIT drops everything at once
    in_valid = 1'b1;
    in_char  = 8'h43;
    tick();
    in_valid = 1'b0;
    tick();
    chk("rw_r_en", r_en, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("rw_r_en_0", r_en, 1'b0);
    chk("rw_out_valid_0", out_valid, 1'b0);
    chk("rw_err_0", err, 1'b0);
    chk("rw_r_offset_0", r_offset, 32'd0);
    chk("rw_r_idx_0", r_idx, 208'd0);
    chk("rw_r_din_0", r_din, 8'h00);
    chk("rw_in_ready", in_ready, 1'b1);
    #10;
    reset_n = 1'b1;
    tick();
    chk("rw_after_err", err, 1'b0);
    chk("rw_after_out_valid", out_valid, 1'b0);
    chk("rw_after_r_en", r_en, 1'b0);

    // Fastest rotor (done one cycle after r_valid), downstream always ready
    in_valid  = 1'b1;
    in_char   = 8'h4D;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    r_done = 1'b1;
    r_dout = 8'h51;
    #1;
    chk("fast_r_en", r_en, 1'b0);
    tick();
    r_done = 1'b0;
    #1;
    chk("fast_out_valid", out_valid, 1'b1);
    chk("fast_out_char", out_char, 8'h51);
    tick();
    chk("fast_out_drop", out_valid, 1'b0);
    chk("fast_in_ready", in_ready, 1'b1);
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
